// File: rtl/axi_10g_ethernet_0_rst_pkg.sv
// Shared definitions for the multi-lane GT reset sequencer: state encoding and width helpers.
package axi_10g_ethernet_0_rst_pkg;

   localparam int unsigned STATE_W = 3;
   localparam int unsigned STAT_W  = 8;

   localparam logic [STATE_W-1:0] ST_QPLL_RST  = 3'd0;
   localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 3'd1;
   localparam logic [STATE_W-1:0] ST_GT_RST    = 3'd2;
   localparam logic [STATE_W-1:0] ST_USRRDY    = 3'd3;
   localparam logic [STATE_W-1:0] ST_WAIT_DONE = 3'd4;
   localparam logic [STATE_W-1:0] ST_DONE      = 3'd5;
   localparam logic [STATE_W-1:0] ST_FAIL      = 3'd6;

   typedef enum logic [STATE_W-1:0] {
      QPLL_RST  = ST_QPLL_RST,
      WAIT_LOCK = ST_WAIT_LOCK,
      GT_RST    = ST_GT_RST,
      USRRDY    = ST_USRRDY,
      WAIT_DONE = ST_WAIT_DONE,
      DONE      = ST_DONE,
      FAIL      = ST_FAIL
   } seq_state_e;

   // Number of bits needed to hold value-1 (ceil(log2(value))).
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned v;
      int unsigned r;
      v = (value > 0) ? value - 1 : 0;
      r = 0;
      for (int unsigned i = 0; i < 32; i++) begin
         if ((v >> i) != 0) r = i + 1;
      end
      return r;
   endfunction

   function automatic int unsigned umax(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/axi_10g_ethernet_0_multi_lane_reset_sequencer_if.sv
// Reset sequencer <-> clocking wrapper / GT channel bundle.
// ETH_RST_STATS_EN adds the lock_loss_cnt / retry_cnt statistics signals.
interface axi_10g_ethernet_0_multi_lane_reset_sequencer_if #(
   parameter int unsigned NUM_LANES = 4
);
   import axi_10g_ethernet_0_rst_pkg::*;

   logic                 qplllock;
   logic [NUM_LANES-1:0] tx_resetdone;
   logic [NUM_LANES-1:0] rx_rst_req;
   logic                 qpllreset;
   logic [NUM_LANES-1:0] gttxreset;
   logic [NUM_LANES-1:0] gtrxreset;
   logic [NUM_LANES-1:0] txuserrdy;
   logic                 reset_counter_done;
   logic                 lock_fail;
   logic [STATE_W-1:0]   seq_state;

`ifdef ETH_RST_STATS_EN
   logic [STAT_W-1:0]    lock_loss_cnt;
   logic [STAT_W-1:0]    retry_cnt;

   modport master (
      input  qplllock, tx_resetdone, rx_rst_req,
      output qpllreset, gttxreset, gtrxreset, txuserrdy, reset_counter_done,
             lock_fail, seq_state, lock_loss_cnt, retry_cnt
   );
   modport slave (
      output qplllock, tx_resetdone, rx_rst_req,
      input  qpllreset, gttxreset, gtrxreset, txuserrdy, reset_counter_done,
             lock_fail, seq_state, lock_loss_cnt, retry_cnt
   );
`else
   modport master (
      input  qplllock, tx_resetdone, rx_rst_req,
      output qpllreset, gttxreset, gtrxreset, txuserrdy, reset_counter_done,
             lock_fail, seq_state
   );
   modport slave (
      output qplllock, tx_resetdone, rx_rst_req,
      input  qpllreset, gttxreset, gtrxreset, txuserrdy, reset_counter_done,
             lock_fail, seq_state
   );
`endif

endinterface

// File: rtl/axi_10g_ethernet_0_lane_rx_reset.sv
// Per-lane gtrxreset: global sequencer reset OR a local fixed-length pulse requested while the link is up.
module axi_10g_ethernet_0_lane_rx_reset
   import axi_10g_ethernet_0_rst_pkg::*;
#(
   parameter int unsigned GT_RST_CYCLES = 8
) (
   input  logic clk,
   input  logic rst,
   input  logic global_rst_i,
   input  logic req_en_i,
   input  logic keep_i,
   input  logic req_i,
   output logic gtrxreset_o
);

   localparam int unsigned CNT_W = clog2(GT_RST_CYCLES) + 1;

   logic             active_q, active_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             gtrxreset_q;

   // Pulse control: abort when leaving DONE, ignore requests while a pulse runs.
   always_comb begin
      active_d = active_q;
      cnt_d    = cnt_q;
      if (!keep_i) begin
         active_d = 1'b0;
         cnt_d    = '0;
      end else if (active_q) begin
         if (cnt_q == CNT_W'(GT_RST_CYCLES - 1)) begin
            active_d = 1'b0;
            cnt_d    = '0;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end else if (req_i && req_en_i) begin
         active_d = 1'b1;
         cnt_d    = '0;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active_q    <= 1'b0;
         cnt_q       <= '0;
         gtrxreset_q <= 1'b1;
      end else begin
         active_q    <= active_d;
         cnt_q       <= cnt_d;
         gtrxreset_q <= global_rst_i | active_d;
      end
   end

   assign gtrxreset_o = gtrxreset_q;

endmodule

// File: rtl/axi_10g_ethernet_0_multi_lane_reset_sequencer.sv
// N-lane QPLL / GT reset sequencer with lock-timeout retry, lock-loss re-sequencing and per-lane RX resets.
// Optional ETH_RST_STATS_EN: lock-loss and lock-timeout statistics counters.
module axi_10g_ethernet_0_multi_lane_reset_sequencer
   import axi_10g_ethernet_0_rst_pkg::*;
#(
   parameter int unsigned NUM_LANES       = 4,
   parameter int unsigned QPLL_RST_CYCLES = 16,
   parameter int unsigned LOCK_TIMEOUT    = 1024,
   parameter int unsigned GT_RST_CYCLES   = 8,
   parameter int unsigned USRRDY_DELAY    = 4,
   parameter int unsigned DONE_TIMEOUT    = 1024,
   parameter int unsigned MAX_RETRIES     = 3
) (
   input logic coreclk,
   input logic areset,
   axi_10g_ethernet_0_multi_lane_reset_sequencer_if.master bus
);

   localparam int unsigned CNT_MAX = umax(umax(QPLL_RST_CYCLES, LOCK_TIMEOUT),
                                          umax(umax(GT_RST_CYCLES, USRRDY_DELAY), DONE_TIMEOUT));
   localparam int unsigned CNT_W   = clog2(CNT_MAX) + 1;
   localparam int unsigned RETRY_W = clog2(MAX_RETRIES) + 1;

   seq_state_e           state_q, state_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic [RETRY_W-1:0]   retry_q, retry_d, retry_inc;
   logic                 lock_meta_q, lock_s_q;
   logic [NUM_LANES-1:0] done_meta_q, done_s_q;
   logic                 qpllreset_q, qpllreset_d;
   logic                 glob_rst_d;
   logic [NUM_LANES-1:0] gttxreset_q;
   logic [NUM_LANES-1:0] txuserrdy_q, txuserrdy_d;
   logic                 done_q, done_d;
   logic                 lock_fail_q, lock_fail_d;
   logic                 req_en_c, keep_c;
   logic [NUM_LANES-1:0] lane_rxrst;

   // Two-flop synchronisers for the asynchronous status inputs.
   always_ff @(posedge coreclk or posedge areset) begin
      if (areset) begin
         lock_meta_q <= 1'b0;
         lock_s_q    <= 1'b0;
         done_meta_q <= '0;
         done_s_q    <= '0;
      end else begin
         lock_meta_q <= bus.qplllock;
         lock_s_q    <= lock_meta_q;
         done_meta_q <= bus.tx_resetdone;
         done_s_q    <= done_meta_q;
      end
   end

   assign retry_inc = (retry_q == '1) ? retry_q : retry_q + 1'b1;

   // Next state, shared phase counter and registered-output decode of the next state.
   always_comb begin
      state_d = state_q;
      cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
      retry_d = retry_q;
      unique case (state_q)
         QPLL_RST:  if (cnt_q == CNT_W'(QPLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
         WAIT_LOCK: begin
            if (lock_s_q) begin
               state_d = GT_RST;
            end else if (cnt_q == CNT_W'(LOCK_TIMEOUT - 1)) begin
               retry_d = retry_inc;
               state_d = (retry_inc >= RETRY_W'(MAX_RETRIES)) ? FAIL : QPLL_RST;
            end
         end
         GT_RST:    if (cnt_q == CNT_W'(GT_RST_CYCLES - 1)) state_d = USRRDY;
         USRRDY:    if (cnt_q == CNT_W'(USRRDY_DELAY - 1)) state_d = WAIT_DONE;
         WAIT_DONE: begin
            if (&done_s_q) state_d = DONE;
            else if (cnt_q == CNT_W'(DONE_TIMEOUT - 1)) state_d = GT_RST;
         end
         DONE:      retry_d = '0;
         FAIL:      state_d = FAIL;
         default:   state_d = QPLL_RST;
      endcase

      // Losing lock after it was acquired always restarts from the QPLL reset.
      if (!lock_s_q && (state_q inside {GT_RST, USRRDY, WAIT_DONE, DONE})) state_d = QPLL_RST;
      if (state_d != state_q) cnt_d = '0;

      qpllreset_d = state_d inside {QPLL_RST, FAIL};
      glob_rst_d  = state_d inside {QPLL_RST, WAIT_LOCK, GT_RST, FAIL};
      txuserrdy_d = {NUM_LANES{state_d inside {WAIT_DONE, DONE}}};
      done_d      = (state_d == DONE);
      lock_fail_d = (state_d == FAIL);
   end

   always_ff @(posedge coreclk or posedge areset) begin
      if (areset) begin
         state_q     <= QPLL_RST;
         cnt_q       <= '0;
         retry_q     <= '0;
         qpllreset_q <= 1'b1;
         gttxreset_q <= '1;
         txuserrdy_q <= '0;
         done_q      <= 1'b0;
         lock_fail_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         retry_q     <= retry_d;
         qpllreset_q <= qpllreset_d;
         gttxreset_q <= {NUM_LANES{glob_rst_d}};
         txuserrdy_q <= txuserrdy_d;
         done_q      <= done_d;
         lock_fail_q <= lock_fail_d;
      end
   end

   // Local RX requests are taken only in DONE and abort as soon as DONE is left.
   assign req_en_c = (state_q == DONE);
   assign keep_c   = (state_d == DONE);

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      axi_10g_ethernet_0_lane_rx_reset #(
         .GT_RST_CYCLES (GT_RST_CYCLES)
      ) u_lane (
         .clk          (coreclk),
         .rst          (areset),
         .global_rst_i (glob_rst_d),
         .req_en_i     (req_en_c),
         .keep_i       (keep_c),
         .req_i        (bus.rx_rst_req[i]),
         .gtrxreset_o  (lane_rxrst[i])
      );
   end

`ifdef ETH_RST_STATS_EN
   logic [STAT_W-1:0] lock_loss_cnt_q;
   logic [STAT_W-1:0] retry_cnt_q;

   // Saturating event counters; lock timeouts are counted whether they retry or fail.
   always_ff @(posedge coreclk or posedge areset) begin
      if (areset) begin
         lock_loss_cnt_q <= '0;
         retry_cnt_q     <= '0;
      end else begin
         if (state_q == DONE && state_d == QPLL_RST && lock_loss_cnt_q != '1)
            lock_loss_cnt_q <= lock_loss_cnt_q + 1'b1;
         if (state_q == WAIT_LOCK && !lock_s_q && cnt_q == CNT_W'(LOCK_TIMEOUT - 1) &&
             retry_cnt_q != '1)
            retry_cnt_q <= retry_cnt_q + 1'b1;
      end
   end

   assign bus.lock_loss_cnt = lock_loss_cnt_q;
   assign bus.retry_cnt     = retry_cnt_q;
`endif

   assign bus.qpllreset          = qpllreset_q;
   assign bus.gttxreset          = gttxreset_q;
   assign bus.gtrxreset          = lane_rxrst;
   assign bus.txuserrdy          = txuserrdy_q;
   assign bus.reset_counter_done = done_q;
   assign bus.lock_fail          = lock_fail_q;
   assign bus.seq_state          = state_q;

endmodule

// File: tb/tb_axi_10g_ethernet_0_multi_lane_reset_sequencer.sv
// Directed bench for the multi-lane reset sequencer; build with ETH_RST_STATS_EN to also check the statistics.
module tb_axi_10g_ethernet_0_multi_lane_reset_sequencer;
   import axi_10g_ethernet_0_rst_pkg::*;

   localparam int unsigned NL = 4;
   // Packed view: {qpllreset, gttxreset, gtrxreset, txuserrdy, done, lock_fail, seq_state}
   localparam logic [17:0] RST_OUTS  = {1'b1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 3'd0};
   localparam logic [17:0] FAIL_OUTS = {1'b1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b1, 3'd6};
   localparam logic [17:0] DONE_OUTS = {1'b0, 4'h0, 4'h0, 4'hF, 1'b1, 1'b0, 3'd5};
   localparam logic [17:0] WL_OUTS   = {1'b0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 3'd1};
   localparam logic [17:0] GTR_OUTS  = {1'b0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 3'd2};
   localparam logic [17:0] USR_OUTS  = {1'b0, 4'h0, 4'h0, 4'h0, 1'b0, 1'b0, 3'd3};
   localparam logic [17:0] WD_OUTS   = {1'b0, 4'h0, 4'h0, 4'hF, 1'b0, 1'b0, 3'd4};

   logic clk = 1'b0;
   logic areset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   axi_10g_ethernet_0_multi_lane_reset_sequencer_if #(.NUM_LANES(NL)) bus ();

   axi_10g_ethernet_0_multi_lane_reset_sequencer #(.NUM_LANES(NL)) dut (
      .coreclk (clk),
      .areset  (areset),
      .bus     (bus.master)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] outs();
      return {bus.qpllreset, bus.gttxreset, bus.gtrxreset, bus.txuserrdy,
              bus.reset_counter_done, bus.lock_fail, bus.seq_state};
   endfunction

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic apply_reset(input logic lock, input logic [NL-1:0] txdone);
      @(negedge clk);
      areset = 1'b1;
      bus.qplllock = lock;
      bus.tx_resetdone = txdone;
      bus.rx_rst_req = '0;
      step(2);
      areset = 1'b0;
   endtask

   task automatic test_reset();
      step(2);
      checks++; if (outs() !== RST_OUTS) begin errors++;
         $display("FAIL reset_outputs: got %h expected %h", outs(), RST_OUTS); end
`ifdef ETH_RST_STATS_EN
      checks++; if ({bus.lock_loss_cnt, bus.retry_cnt} !== 16'h0) begin errors++;
         $display("FAIL reset_stats: got %h expected 0000", {bus.lock_loss_cnt, bus.retry_cnt}); end
`endif
   endtask

   task automatic test_normal_sequence();
      apply_reset(1'b0, '0);
      step(15);
      checks++; if (outs() !== RST_OUTS) begin errors++;
         $display("FAIL qpll_rst_hold15: got %h expected %h", outs(), RST_OUTS); end
      step(1);
      checks++; if (outs() !== WL_OUTS) begin errors++;
         $display("FAIL wait_lock_entry: got %h expected %h", outs(), WL_OUTS); end
      step(34);
      bus.qplllock = 1'b1;
      step(2);
      checks++; if (bus.seq_state !== ST_WAIT_LOCK) begin errors++;
         $display("FAIL lock_sync_latency: got %0d expected 1", bus.seq_state); end
      step(1);
      checks++; if (outs() !== GTR_OUTS) begin errors++;
         $display("FAIL gt_rst_entry: got %h expected %h", outs(), GTR_OUTS); end
      step(7);
      checks++; if (outs() !== GTR_OUTS) begin errors++;
         $display("FAIL gt_rst_hold8: got %h expected %h", outs(), GTR_OUTS); end
      step(1);
      checks++; if (outs() !== USR_OUTS) begin errors++;
         $display("FAIL usrrdy_entry: got %h expected %h", outs(), USR_OUTS); end
      step(3);
      checks++; if (bus.txuserrdy !== 4'h0) begin errors++;
         $display("FAIL usrrdy_delay: got %h expected 0", bus.txuserrdy); end
      step(1);
      checks++; if (outs() !== WD_OUTS) begin errors++;
         $display("FAIL wait_done_entry: got %h expected %h", outs(), WD_OUTS); end
      step(5);
      bus.tx_resetdone = 4'hF;
      step(2);
      checks++; if (outs() !== WD_OUTS) begin errors++;
         $display("FAIL resetdone_sync: got %h expected %h", outs(), WD_OUTS); end
      step(1);
      checks++; if (outs() !== DONE_OUTS) begin errors++;
         $display("FAIL done_entry: got %h expected %h", outs(), DONE_OUTS); end
   endtask

   task automatic test_rx_reset();
      bus.rx_rst_req = 4'b0100;
      step(1);
      bus.rx_rst_req = 4'b0000;
      checks++; if (bus.gtrxreset !== 4'b0100) begin errors++;
         $display("FAIL rx_pulse_start: got %b expected 0100", bus.gtrxreset); end
      step(2);
      bus.rx_rst_req = 4'b0100;
      step(1);
      bus.rx_rst_req = 4'b0000;
      checks++; if (bus.gtrxreset !== 4'b0100) begin errors++;
         $display("FAIL rx_pulse_mid: got %b expected 0100", bus.gtrxreset); end
      step(4);
      checks++; if (bus.gtrxreset !== 4'b0100) begin errors++;
         $display("FAIL rx_pulse_last: got %b expected 0100", bus.gtrxreset); end
      step(1);
      checks++; if (bus.gtrxreset !== 4'b0000) begin errors++;
         $display("FAIL rx_pulse_no_extend: got %b expected 0000", bus.gtrxreset); end
      checks++; if (outs() !== DONE_OUTS) begin errors++;
         $display("FAIL rx_done_kept: got %h expected %h", outs(), DONE_OUTS); end
      bus.rx_rst_req = 4'b0001;
      step(1);
      bus.rx_rst_req = 4'b1000;
      checks++; if (bus.gtrxreset !== 4'b0001) begin errors++;
         $display("FAIL rx_lane0_start: got %b expected 0001", bus.gtrxreset); end
      step(1);
      bus.rx_rst_req = 4'b0000;
      checks++; if (bus.gtrxreset !== 4'b1001) begin errors++;
         $display("FAIL rx_two_lanes: got %b expected 1001", bus.gtrxreset); end
      step(7);
      checks++; if (bus.gtrxreset !== 4'b1000) begin errors++;
         $display("FAIL rx_lane0_end: got %b expected 1000", bus.gtrxreset); end
      step(1);
      checks++; if (bus.gtrxreset !== 4'b0000) begin errors++;
         $display("FAIL rx_lane3_end: got %b expected 0000", bus.gtrxreset); end
   endtask

   task automatic test_lock_loss();
      bus.qplllock = 1'b0;
      step(2);
      checks++; if (outs() !== DONE_OUTS) begin errors++;
         $display("FAIL loss_sync_hold: got %h expected %h", outs(), DONE_OUTS); end
      step(1);
      checks++; if (outs() !== RST_OUTS) begin errors++;
         $display("FAIL loss_to_qpll_rst: got %h expected %h", outs(), RST_OUTS); end
`ifdef ETH_RST_STATS_EN
      checks++; if (bus.lock_loss_cnt !== 8'd1) begin errors++;
         $display("FAIL loss_cnt_1: got %0d expected 1", bus.lock_loss_cnt); end
`endif
      bus.qplllock = 1'b1;
      step(15);
      checks++; if (outs() !== RST_OUTS) begin errors++;
         $display("FAIL reseq_qpll_hold: got %h expected %h", outs(), RST_OUTS); end
      step(1);
      checks++; if (bus.seq_state !== ST_WAIT_LOCK) begin errors++;
         $display("FAIL reseq_wait_lock: got %0d expected 1", bus.seq_state); end
      step(1);
      checks++; if (bus.seq_state !== ST_GT_RST) begin errors++;
         $display("FAIL reseq_gt_rst: got %0d expected 2", bus.seq_state); end
      step(13);
      checks++; if (outs() !== DONE_OUTS) begin errors++;
         $display("FAIL reseq_done: got %h expected %h", outs(), DONE_OUTS); end
   endtask

   task automatic test_areset_mid_wait_done();
      bus.qplllock = 1'b0;
      bus.tx_resetdone = 4'h0;
      step(3);
      checks++; if (bus.seq_state !== ST_QPLL_RST) begin errors++;
         $display("FAIL loss2_qpll_rst: got %0d expected 0", bus.seq_state); end
      bus.qplllock = 1'b1;
      step(29);
      checks++; if (outs() !== WD_OUTS) begin errors++;
         $display("FAIL stuck_wait_done: got %h expected %h", outs(), WD_OUTS); end
`ifdef ETH_RST_STATS_EN
      checks++; if (bus.lock_loss_cnt !== 8'd2) begin errors++;
         $display("FAIL loss_cnt_2: got %0d expected 2", bus.lock_loss_cnt); end
`endif
      #2 areset = 1'b1;
      #1;
      checks++; if (outs() !== RST_OUTS) begin errors++;
         $display("FAIL async_reset_outputs: got %h expected %h", outs(), RST_OUTS); end
`ifdef ETH_RST_STATS_EN
      checks++; if ({bus.lock_loss_cnt, bus.retry_cnt} !== 16'h0) begin errors++;
         $display("FAIL async_reset_stats: got %h expected 0000", {bus.lock_loss_cnt, bus.retry_cnt}); end
`endif
   endtask

   task automatic test_done_timeout();
      apply_reset(1'b1, 4'b1101);
      step(29);
      checks++; if (outs() !== WD_OUTS) begin errors++;
         $display("FAIL to_wait_done: got %h expected %h", outs(), WD_OUTS); end
      bus.rx_rst_req = 4'hF;
      step(1);
      bus.rx_rst_req = 4'h0;
      checks++; if (bus.gtrxreset !== 4'h0) begin errors++;
         $display("FAIL rx_req_outside_done: got %b expected 0000", bus.gtrxreset); end
      step(1022);
      checks++; if (bus.seq_state !== ST_WAIT_DONE) begin errors++;
         $display("FAIL to_before_expiry: got %0d expected 4", bus.seq_state); end
      step(1);
      checks++; if (outs() !== GTR_OUTS) begin errors++;
         $display("FAIL to_gt_rst_1: got %h expected %h", outs(), GTR_OUTS); end
      step(12);
      checks++; if (bus.seq_state !== ST_WAIT_DONE) begin errors++;
         $display("FAIL to_wait_done_2: got %0d expected 4", bus.seq_state); end
      step(1023);
      checks++; if (bus.seq_state !== ST_WAIT_DONE) begin errors++;
         $display("FAIL to_before_expiry_2: got %0d expected 4", bus.seq_state); end
      step(1);
      checks++; if (outs() !== GTR_OUTS) begin errors++;
         $display("FAIL to_gt_rst_2: got %h expected %h", outs(), GTR_OUTS); end
`ifdef ETH_RST_STATS_EN
      checks++; if (bus.retry_cnt !== 8'd0) begin errors++;
         $display("FAIL to_no_retry: got %0d expected 0", bus.retry_cnt); end
`endif
   endtask

   task automatic test_lock_timeout_fail();
      apply_reset(1'b0, 4'h0);
      step(1039);
      checks++; if (outs() !== WL_OUTS) begin errors++;
         $display("FAIL lt_before_1: got %h expected %h", outs(), WL_OUTS); end
      step(1);
      checks++; if (outs() !== RST_OUTS) begin errors++;
         $display("FAIL lt_retry_1: got %h expected %h", outs(), RST_OUTS); end
      step(16);
      checks++; if (bus.seq_state !== ST_WAIT_LOCK) begin errors++;
         $display("FAIL lt_wait_2: got %0d expected 1", bus.seq_state); end
      step(1024);
      checks++; if (bus.seq_state !== ST_QPLL_RST) begin errors++;
         $display("FAIL lt_retry_2: got %0d expected 0", bus.seq_state); end
      step(1039);
      checks++; if (outs() !== WL_OUTS) begin errors++;
         $display("FAIL lt_before_3: got %h expected %h", outs(), WL_OUTS); end
      step(1);
      checks++; if (outs() !== FAIL_OUTS) begin errors++;
         $display("FAIL lt_enter_fail: got %h expected %h", outs(), FAIL_OUTS); end
`ifdef ETH_RST_STATS_EN
      checks++; if ({bus.lock_loss_cnt, bus.retry_cnt} !== {8'd0, 8'd3}) begin errors++;
         $display("FAIL lt_stats: got %h expected 0003", {bus.lock_loss_cnt, bus.retry_cnt}); end
`endif
      bus.qplllock = 1'b1;
      bus.tx_resetdone = 4'hF;
      step(20);
      checks++; if (outs() !== FAIL_OUTS) begin errors++;
         $display("FAIL lt_fail_sticky: got %h expected %h", outs(), FAIL_OUTS); end
   endtask

   initial begin
      bus.qplllock = 1'b0;
      bus.tx_resetdone = '0;
      bus.rx_rst_req = '0;
      test_reset();
      test_normal_sequence();
      test_rx_reset();
      test_lock_loss();
      test_areset_mid_wait_done();
      test_done_timeout();
      test_lock_timeout_fail();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
